// File: rtl/nem_ohmux_sel_ctrl.sv
// ---------------------------------------------------------------------------
// nem_ohmux_sel_ctrl
//
// Select-side sequencer for the NEM one-hot inverting mux cells.
// A binary input index arrives over a valid/ready handshake. The block drives
// the one-hot relay gate bus S with break-before-make timing, so no two relays
// are ever closed at the same time. Every change of selection passes through
// an all-open interval (BREAK), then the new relay is held closed for a
// mechanical settle time (SETTLE) before done is pulsed.
//
// State sequence
//   IDLE   : S = 0, ready for a request
//   BREAK  : S = 0 for BREAK_CYC cycles (only when switching between relays)
//   SETTLE : S = onehot(cur_sel) for SETTLE_CYC cycles
//   HOLD   : S = onehot(cur_sel), ready for a request or off_i
//
// Optional feature (macro NEM_OHMUX_CAPTURE_EN):
//   Adds zn_i (mux ZN outputs) and data_o. data_o captures ~zn_i on the same
//   edge that raises done and holds otherwise. Without the macro the two
//   ports are absent and all other behaviour is identical.
//
// Parameters
//   N_IN        number of mux inputs / width of S (>= 2)
//   SEL_W       width of req_sel, $clog2(N_IN)
//   BREAK_CYC   all-open cycles before a new relay closes (>= 1)
//   SETTLE_CYC  cycles the new relay is closed before done (>= 1)
//   CNT_W       dead-time counter width
//   DATA_W      mux data width (capture feature only)
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active high
//   req_valid  in   1       selection request valid
//   req_ready  out  1       request can be accepted this cycle
//   req_sel    in   SEL_W   binary index of the input to select
//   off_i      in   1       open all relays (return to IDLE from HOLD)
//   S          out  N_IN    one-hot relay gate drive (all-zero = none)
//   busy       out  1       high in BREAK and SETTLE
//   done       out  1       one-cycle pulse: selection has settled
//   err        out  1       one-cycle pulse: request rejected (req_sel >= N_IN)
//   zn_i       in   DATA_W  mux ZN outputs          (capture feature only)
//   data_o     out  DATA_W  captured ~zn_i at done  (capture feature only)
// ---------------------------------------------------------------------------
module nem_ohmux_sel_ctrl #(
  parameter int N_IN       = 4,
  parameter int SEL_W      = 2,
  parameter int BREAK_CYC  = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic              off_i,
  output logic [N_IN-1:0]   S,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef NEM_OHMUX_CAPTURE_EN
  ,
  input  logic [DATA_W-1:0] zn_i,
  output logic [DATA_W-1:0] data_o
`endif
);

  // Elaboration-time parameter sanity checks.
  generate
    if (N_IN < 2)                              $error("N_IN must be >= 2");
    if (SEL_W != $clog2(N_IN))                 $error("SEL_W must equal clog2(N_IN)");
    if (BREAK_CYC < 1 || SETTLE_CYC < 1)       $error("BREAK_CYC/SETTLE_CYC must be >= 1");
    if ((BREAK_CYC - 1) >= (2 ** CNT_W))       $error("CNT_W too small for BREAK_CYC");
    if ((SETTLE_CYC - 1) >= (2 ** CNT_W))      $error("CNT_W too small for SETTLE_CYC");
    if (DATA_W < 1)                            $error("DATA_W must be >= 1");
  endgenerate

  localparam logic [CNT_W-1:0] BREAK_LD  = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  cur_sel;

  // Decode a binary index to one-hot. Written as a compare loop so that an
  // out-of-range index (non-power-of-two N_IN) simply yields all zeros.
  function automatic logic [N_IN-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_IN-1:0] v;
    v = '0;
    for (int i = 0; i < N_IN; i++) begin
      v[i] = (int'(sel) == i);
    end
    return v;
  endfunction

  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    return int'(sel) < N_IN;
  endfunction

  // Handshake decode. req_ready is itself a register (high in IDLE/HOLD),
  // so accept is a clean AND of the request with registered state.
  logic accept;
  logic sel_ok;
  logic same_sel;
  logic done_set;

  always_comb begin
    accept   = req_valid & req_ready;
    sel_ok   = sel_in_range(req_sel);
    same_sel = (req_sel == cur_sel);
    // done rises either at the end of SETTLE or on a repeat of the held index.
    done_set = ((state == SETTLE) && (cnt == '0)) ||
               ((state == HOLD) && accept && sel_ok && same_sel);
  end

  // Sequencer: state, dead-time counter, selection and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_sel   <= '0;
      S         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= done_set;
      // A rejected index only pulses err; state and S are left untouched.
      err  <= accept & ~sel_ok;

      unique case (state)
        IDLE: begin
          // Nothing is closed, so no break interval is needed.
          if (accept && sel_ok) begin
            state     <= SETTLE;
            cur_sel   <= req_sel;
            cnt       <= SETTLE_LD;
            S         <= onehot(req_sel);
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end
        end

        BREAK: begin
          // off_i is deliberately ignored: a sequence is never aborted.
          if (cnt == '0) begin
            state <= SETTLE;
            cnt   <= SETTLE_LD;
            S     <= onehot(cur_sel);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          // Any accepted request takes priority over a simultaneous off_i.
          if (accept) begin
            if (sel_ok && !same_sel) begin
              state     <= BREAK;
              cur_sel   <= req_sel;
              cnt       <= BREAK_LD;
              S         <= '0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end
          end else if (off_i) begin
            state <= IDLE;
            S     <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          S         <= '0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef NEM_OHMUX_CAPTURE_EN
  // Capture the inverted mux output on the edge that reports the selection
  // as settled, so data_o always reflects a fully settled relay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o <= '0;
    end else if (done_set) begin
      data_o <= ~zn_i;
    end
  end
`endif

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
`timescale 1ns/1ps
module tb_nem_ohmux_sel_ctrl;

  localparam int BRK = 4;
  localparam int STL = 8;
  localparam int DW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_ready, off_i, busy, done, err;
  logic [1:0] req_sel;
  logic [3:0] S;

  logic       r3_valid, r3_ready, r3_off, busy3, done3, err3;
  logic [1:0] r3_sel;
  logic [2:0] S3;

`ifdef NEM_OHMUX_CAPTURE_EN
  logic [DW-1:0] zn, data, data3;
`endif

  nem_ohmux_sel_ctrl #(
    .N_IN(4), .SEL_W(2), .BREAK_CYC(BRK), .SETTLE_CYC(STL), .CNT_W(8), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .off_i(off_i), .S(S), .busy(busy), .done(done), .err(err)
`ifdef NEM_OHMUX_CAPTURE_EN
    , .zn_i(zn), .data_o(data)
`endif
  );

  nem_ohmux_sel_ctrl #(
    .N_IN(3), .SEL_W(2), .BREAK_CYC(BRK), .SETTLE_CYC(STL), .CNT_W(8), .DATA_W(DW)
  ) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_sel(r3_sel), .off_i(r3_off), .S(S3), .busy(busy3), .done(done3), .err(err3)
`ifdef NEM_OHMUX_CAPTURE_EN
    , .zn_i(zn), .data_o(data3)
`endif
  );

  // Scoreboard entry: expected {S, done, busy, req_ready} for one cycle.
  typedef struct packed {
    logic [3:0] s;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model of the main DUT's selection state.
  bit   m_hold = 1'b0;
  int   m_sel  = 0;

  function automatic exp_t mk(input logic [3:0] s, input logic d, input logic b, input logic r);
    exp_t e;
    e.s = s; e.done = d; e.busy = b; e.ready = r;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the main DUT and push the expected per-cycle
  // response, starting with the cycle after the accept edge.
  task automatic send(input int sel, input logic with_off);
    logic [3:0] oh;
    oh        = 4'b0001 << sel;
    req_valid = 1'b1;
    req_sel   = 2'(sel);
    off_i     = with_off;
    if (m_hold && sel == m_sel) begin
      exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b1));
    end else begin
      if (m_hold) repeat (BRK) exp_q.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0));
      repeat (STL) exp_q.push_back(mk(oh, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b1));
    end
    m_hold = 1'b1;
    m_sel  = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; off_i = 1'b0;
    r3_valid = 1'b0; r3_sel = '0; r3_off = 1'b0;
`ifdef NEM_OHMUX_CAPTURE_EN
    zn = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({S, busy, done, err, req_ready} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_main: {S,busy,done,err,ready}=%b expected 00000001", {S, busy, done, err, req_ready});
    end
    n_cmp++;
    if ({S3, busy3, done3, err3, r3_ready} !== 7'b000_0001) begin
      n_err++;
      $display("FAIL reset_n3: {S,busy,done,err,ready}=%b expected 0000001", {S3, busy3, done3, err3, r3_ready});
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    n_cmp++;
    if (data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: data_o=%h expected 00", data);
    end
`endif
    #2 rst = 1'b0;
    step();
    n_cmp++;
    if (S !== 4'b0000 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: S=%b ready=%b busy=%b expected 0000/1/0", S, req_ready, busy);
    end
    m_hold = 1'b0;
  endtask

  task automatic test_idle_select();
    exp_t e;
`ifdef NEM_OHMUX_CAPTURE_EN
    zn = 8'hA5;
`endif
    send(2, 1'b0);
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL idle_select: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    n_cmp++;
    if (data !== 8'h5A) begin
      n_err++;
      $display("FAIL capture_a5: data_o=%h expected 5a", data);
    end
    zn = 8'h00;
`endif
    repeat (3) begin
      step();
      n_cmp++;
      if (S !== 4'b0100 || done !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL hold_steady: S=%b done=%b ready=%b expected 0100/0/1", S, done, req_ready);
      end
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    n_cmp++;
    if (data !== 8'h5A) begin
      n_err++;
      $display("FAIL capture_hold: data_o=%h expected 5a", data);
    end
`endif
  endtask

  task automatic test_switch();
    exp_t       e;
    logic [3:0] prev;
    prev = S;
    send(0, 1'b0);
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL switch: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
      n_cmp++;
      if ($countones(S) > 1 || (prev != 4'b0000 && S != 4'b0000 && S != prev)) begin
        n_err++;
        $display("FAIL bbm_invariant: S=%b prev=%b expected popcount<=1 and change via zero", S, prev);
      end
      prev = S;
    end
  endtask

  task automatic test_same_sel();
    exp_t e;
    send(1, 1'b0);
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL to_sel1: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    zn = 8'h3C;
`endif
    send(1, 1'b0);
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL same_sel: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || S !== 4'b0010) begin
      n_err++;
      $display("FAIL same_sel_pulse: done=%b S=%b expected 0/0010", done, S);
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    n_cmp++;
    if (data !== 8'hC3) begin
      n_err++;
      $display("FAIL capture_3c: data_o=%h expected c3", data);
    end
`endif
  endtask

  task automatic test_err();
    r3_valid = 1'b1; r3_sel = 2'd1;
    for (int j = 1; j <= STL + 1; j++) begin
      step();
      r3_valid = 1'b0;
      n_cmp++;
      if (j <= STL) begin
        if (S3 !== 3'b010 || done3 !== 1'b0 || r3_ready !== 1'b0 || busy3 !== 1'b1) begin
          n_err++;
          $display("FAIL n3_settle j=%0d: S=%b done=%b ready=%b busy=%b expected 010/0/0/1", j, S3, done3, r3_ready, busy3);
        end
      end else if (S3 !== 3'b010 || done3 !== 1'b1 || r3_ready !== 1'b1) begin
        n_err++;
        $display("FAIL n3_done: S=%b done=%b ready=%b expected 010/1/1", S3, done3, r3_ready);
      end
    end
    r3_valid = 1'b1; r3_sel = 2'd1;
    step(); r3_valid = 1'b0;
    n_cmp++;
    if (done3 !== 1'b1 || S3 !== 3'b010 || err3 !== 1'b0) begin
      n_err++;
      $display("FAIL n3_same: done=%b S=%b err=%b expected 1/010/0", done3, S3, err3);
    end
    r3_valid = 1'b1; r3_sel = 2'd3;
    step(); r3_valid = 1'b0;
    n_cmp++;
    if (err3 !== 1'b1 || S3 !== 3'b010 || done3 !== 1'b0 || r3_ready !== 1'b1 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL n3_err: err=%b S=%b done=%b ready=%b busy=%b expected 1/010/0/1/0", err3, S3, done3, r3_ready, busy3);
    end
    step();
    n_cmp++;
    if (err3 !== 1'b0 || S3 !== 3'b010) begin
      n_err++;
      $display("FAIL n3_err_pulse: err=%b S=%b expected 0/010", err3, S3);
    end
  endtask

  task automatic test_off();
    exp_t e;
    int   j;
    off_i = 1'b1;
    step(); off_i = 1'b0;
    n_cmp++;
    if (S !== 4'b0000 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL off_hold: S=%b ready=%b busy=%b done=%b expected 0000/1/0/0", S, req_ready, busy, done);
    end
    m_hold = 1'b0;
    // From IDLE the next request must skip BREAK; off_i pulsed mid-SETTLE.
    send(3, 1'b0);
    j = 0;
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0; j++;
      if (j == 3 || j == 4) off_i = 1'b1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL off_in_settle: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
    end
    // off_i together with an accepted request: the request proceeds.
    send(2, 1'b1);
    while (exp_q.size() > 0) begin
      step(); req_valid = 1'b0; off_i = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({S, done, busy, req_ready} !== e) begin
        n_err++;
        $display("FAIL off_with_accept: {S,done,busy,ready}=%b expected %b", {S, done, busy, req_ready}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    send(1, 1'b0);
    repeat (BRK + 3) begin
      step(); req_valid = 1'b0;
    end
    exp_q.delete();
    n_cmp++;
    if (S !== 4'b0010 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_async_rst: S=%b busy=%b expected 0010/1", S, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (S !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_rst: S=%b busy=%b done=%b ready=%b expected 0000/0/0/1", S, busy, done, req_ready);
    end
`ifdef NEM_OHMUX_CAPTURE_EN
    n_cmp++;
    if (data !== 8'h00) begin
      n_err++;
      $display("FAIL async_rst_data: data_o=%h expected 00", data);
    end
`endif
    #2 rst = 1'b0;
    m_hold = 1'b0;
    for (int j = 0; j < STL + BRK + 3; j++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || S !== 4'b0000) begin
        n_err++;
        $display("FAIL no_done_after_rst j=%0d: done=%b S=%b expected 0/0000", j, done, S);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_select();
    test_switch();
    test_same_sel();
    test_err();
    test_off();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
